// File: rtl/zion_basic_circuit_lib_pkg.sv
`default_nettype none
// ============================================================================
// Module  : zion_basic_circuit_lib_pkg
// Brief   : Shared types for the basic circuit library (write-merge FSM states)
// Revision: 1.0 - initial release
// ============================================================================
package zion_basic_circuit_lib_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    ISSUE = 2'd2
  } wmState_t;

endpackage
`default_nettype wire

// File: rtl/zion_basic_circuit_lib_lane_decode.sv
`default_nettype none
// ============================================================================
// Module  : zion_basic_circuit_lib_lane_decode
// Brief   : Lane index to one-hot lane-select decoder with enable
// Revision: 1.0 - initial release
// ============================================================================
module zion_basic_circuit_lib_lane_decode #(
  parameter int LANES     = 4,
  parameter int WIDTH_SEL = 2
) (
  input  logic                 iEn,
  input  logic [WIDTH_SEL-1:0] iIdx,
  output logic [LANES-1:0]     oSel
);

  for (genvar k = 0; k < LANES; k++) begin : g_sel
    assign oSel[k] = iEn && (iIdx == WIDTH_SEL'(k));
  end

endmodule
`default_nettype wire

// File: rtl/zion_basic_circuit_lib_write_merge_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : zion_basic_circuit_lib_write_merge_ctrl
// Brief   : Merges narrow lane writes into one masked memory-line write
// Revision: 1.0 - initial release
// ============================================================================
module zion_basic_circuit_lib_write_merge_ctrl
  import zion_basic_circuit_lib_pkg::*;
#(
  parameter int WIDTH_ADDR     = 8,
  parameter int WIDTH_DATA_IN  = 8,
  parameter int WIDTH_DATA_OUT = 32,
  parameter int TIMEOUT        = 4,
  parameter int MASK_FLAG      = 0,
  localparam int c_LANES       = WIDTH_DATA_OUT / WIDTH_DATA_IN,
  localparam int c_LB          = $clog2(c_LANES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iVld,
  output logic                       oRdy,
  input  logic [WIDTH_ADDR-1:0]      iAddr,
  input  logic [WIDTH_DATA_IN-1:0]   iDat,
  input  logic                       iFlush,
  output logic                       oWrVld,
  input  logic                       iWrRdy,
  output logic [WIDTH_ADDR-c_LB-1:0] oWrAddr,
  output logic [WIDTH_DATA_OUT-1:0]  oWrDat,
  output logic [c_LANES-1:0]         oWrMask,
  output logic                       oIdle
);

  localparam int c_LBW = (c_LB > 0) ? c_LB : 1;
  localparam int c_WL  = WIDTH_ADDR - c_LB;
  localparam int c_TW  = $clog2(TIMEOUT + 1);
  localparam logic [c_LANES-1:0] c_MASK_OFF = (MASK_FLAG != 0) ? '1 : '0;

  wmState_t                  r_state;
  logic [c_WL-1:0]           r_line;
  logic [WIDTH_DATA_OUT-1:0] r_dat;
  logic [c_LANES-1:0]        r_mask;
  logic [c_TW-1:0]           r_timer;
  logic                      r_wrVld;
  logic                      r_idle;

  logic [c_WL-1:0]           w_line;
  logic [c_LBW-1:0]          w_lane;
  logic                      w_lineHit;
  logic                      w_accept;
  logic                      w_full;
  logic                      w_timeout;
  logic [c_LANES-1:0]        w_laneSel;
  logic [c_LANES-1:0]        w_written;
  logic [c_LANES-1:0]        w_writtenNext;
  logic [WIDTH_DATA_OUT-1:0] w_datNext;
  logic [c_TW-1:0]           w_timerInc;

  assign w_line = iAddr[WIDTH_ADDR-1:c_LB];

  if (c_LB > 0) begin : g_laneIdx
    assign w_lane = iAddr[c_LBW-1:0];
  end else begin : g_laneSingle
    assign w_lane = '0;
  end

  assign w_lineHit = (w_line == r_line);

  // Ready is a handshake term: it must see this cycle's iVld/iAddr, so it is
  // decoded from the registered state rather than registered itself.
  always_comb begin
    oRdy = 1'b0;
    case (r_state)
      IDLE:    oRdy = 1'b1;
      MERGE:   oRdy = !iVld || w_lineHit;
      default: oRdy = 1'b0;
    endcase
  end

  assign w_accept = iVld && oRdy;

  zion_basic_circuit_lib_lane_decode #(
    .LANES     (c_LANES),
    .WIDTH_SEL (c_LBW)
  ) u_laneDecode (
    .iEn  (w_accept),
    .iIdx (w_lane),
    .oSel (w_laneSel)
  );

  // r_mask is held in output polarity; XOR with the inactive pattern gives
  // an active-high "lane written" view for the merge logic.
  assign w_written     = r_mask ^ c_MASK_OFF;
  assign w_writtenNext = w_written | w_laneSel;
  assign w_full        = &w_writtenNext;
  assign w_timerInc    = r_timer + c_TW'(1);
  assign w_timeout     = (w_timerInc >= c_TW'(TIMEOUT));

  for (genvar k = 0; k < c_LANES; k++) begin : g_lane
    assign w_datNext[k*WIDTH_DATA_IN +: WIDTH_DATA_IN] =
      w_laneSel[k] ? iDat : r_dat[k*WIDTH_DATA_IN +: WIDTH_DATA_IN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_line  <= '0;
      r_dat   <= '0;
      r_mask  <= c_MASK_OFF;
      r_timer <= '0;
      r_wrVld <= 1'b0;
      r_idle  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_line  <= w_line;
            r_dat   <= w_datNext;
            r_mask  <= w_writtenNext ^ c_MASK_OFF;
            r_timer <= '0;
            r_idle  <= 1'b0;
            if (w_full) begin
              r_state <= ISSUE;
              r_wrVld <= 1'b1;
            end else begin
              r_state <= MERGE;
            end
          end
        end
        MERGE: begin
          if (w_accept) begin
            r_dat   <= w_datNext;
            r_mask  <= w_writtenNext ^ c_MASK_OFF;
            r_timer <= '0;
            if (w_full || iFlush) begin
              r_state <= ISSUE;
              r_wrVld <= 1'b1;
            end
          end else if (iVld || iFlush || w_timeout) begin
            r_state <= ISSUE;
            r_wrVld <= 1'b1;
          end else begin
            r_timer <= w_timerInc;
          end
        end
        ISSUE: begin
          if (iWrRdy) begin
            r_state <= IDLE;
            r_wrVld <= 1'b0;
            r_dat   <= '0;
            r_mask  <= c_MASK_OFF;
            r_timer <= '0;
            r_idle  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oWrVld  = r_wrVld;
  assign oWrAddr = r_line;
  assign oWrDat  = r_dat;
  assign oWrMask = r_mask;
  assign oIdle   = r_idle;

endmodule
`default_nettype wire

// File: tb/tb_zion_basic_circuit_lib_write_merge_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_zion_basic_circuit_lib_write_merge_ctrl
// Brief   : Directed self-checking bench with a per-cycle line-buffer model
// Revision: 1.0 - initial release
// ============================================================================
module tb_zion_basic_circuit_lib_write_merge_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iVld = 1'b0;
  logic        iFlush = 1'b0;
  logic        iWrRdy = 1'b0;
  logic [7:0]  iAddr = '0;
  logic [7:0]  iDat = '0;
  logic        oRdy;
  logic        oWrVld;
  logic        oIdle;
  logic [5:0]  oWrAddr;
  logic [31:0] oWrDat;
  logic [3:0]  oWrMask;

  int nChecks = 0;
  int nErrors = 0;

  // Model: a pending line as four lane slots (-1 = never written)
  int mLane[4];
  bit mPending = 1'b0;
  bit mIssuing = 1'b0;
  bit mValid = 1'b0;
  int mLine = 0;
  int mIdle = 0;
  int mXfers = 0;
  int dutXfers = 0;

  always #5 clk = ~clk;

  zion_basic_circuit_lib_write_merge_ctrl #(
    .WIDTH_ADDR     (8),
    .WIDTH_DATA_IN  (8),
    .WIDTH_DATA_OUT (32),
    .TIMEOUT        (TIMEOUT),
    .MASK_FLAG      (0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .iVld    (iVld),
    .oRdy    (oRdy),
    .iAddr   (iAddr),
    .iDat    (iDat),
    .iFlush  (iFlush),
    .oWrVld  (oWrVld),
    .iWrRdy  (iWrRdy),
    .oWrAddr (oWrAddr),
    .oWrDat  (oWrDat),
    .oWrMask (oWrMask),
    .oIdle   (oIdle)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit mFull();
    for (int k = 0; k < 4; k++) if (mLane[k] < 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] mDat();
    logic [31:0] d = '0;
    for (int k = 0; k < 4; k++) if (mLane[k] >= 0) d |= 32'(mLane[k]) << (8 * k);
    return d;
  endfunction

  function automatic logic [3:0] mMask();
    logic [3:0] m = '0;
    for (int k = 0; k < 4; k++) m[k] = (mLane[k] >= 0);
    return m;
  endfunction

  // Model update at the active edge using the inputs presented for that edge
  initial begin
    int ln;
    forever begin
      @(posedge clk);
      if (oWrVld === 1'b1 && iWrRdy && !rst) dutXfers++;
      ln = int'(iAddr) % 4;
      if (rst) begin
        mPending = 1'b0; mIssuing = 1'b0; mLine = 0; mIdle = 0; mValid = 1'b1;
        for (int k = 0; k < 4; k++) mLane[k] = -1;
      end else if (mIssuing) begin
        if (iWrRdy) begin
          mXfers++;
          mPending = 1'b0; mIssuing = 1'b0;
          for (int k = 0; k < 4; k++) mLane[k] = -1;
        end
      end else if (!mPending) begin
        if (iVld) begin
          mLine = int'(iAddr) / 4; mLane[ln] = int'(iDat);
          mPending = 1'b1; mIdle = 0;
          if (mFull()) mIssuing = 1'b1;
        end
      end else if (iVld && (int'(iAddr) / 4 == mLine)) begin
        mLane[ln] = int'(iDat); mIdle = 0;
        if (mFull() || iFlush) mIssuing = 1'b1;
      end else if (iVld || iFlush) begin
        mIssuing = 1'b1;
      end else begin
        mIdle++;
        if (mIdle >= TIMEOUT) mIssuing = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (mValid) begin
      chk("mdl_wrVld", oWrVld, mIssuing);
      chk("mdl_idle", oIdle, !mPending);
      chk("mdl_rdy", oRdy, !mIssuing && (!mPending || !iVld || (int'(iAddr) / 4 == mLine)));
      chk("mdl_mask", oWrMask, mMask());
      chk("mdl_dat", oWrDat, mDat());
      if (mPending) chk("mdl_addr", oWrAddr, 6'(mLine));
      chk("mdl_xfers", dutXfers, mXfers);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    iVld = 1'b1; iAddr = a; iDat = d;
    step();
    iVld = 1'b0;
  endtask

  task automatic drain();
    iWrRdy = 1'b1;
    step();
    iWrRdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_idle", oIdle, 1); chk("rst_vld", oWrVld, 0);
    chk("rst_mask", oWrMask, 4'b0000); chk("rst_dat", oWrDat, 32'h0); chk("rst_rdy", oRdy, 1);

    iFlush = 1'b1; step(); iFlush = 1'b0;
    chk("flushIdle_idle", oIdle, 1); chk("flushIdle_vld", oWrVld, 0);

    // Full line from four back-to-back writes, then a 5-cycle stall
    wr(8'h10, 8'hAA); wr(8'h11, 8'hBB); wr(8'h12, 8'hCC); wr(8'h13, 8'hDD);
    chk("b2b_vld", oWrVld, 1); chk("b2b_addr", oWrAddr, 6'h04);
    chk("b2b_dat", oWrDat, 32'hDDCCBBAA); chk("b2b_mask", oWrMask, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_vld", oWrVld, 1); chk("stall_addr", oWrAddr, 6'h04);
      chk("stall_dat", oWrDat, 32'hDDCCBBAA); chk("stall_mask", oWrMask, 4'b1111);
      chk("stall_rdy", oRdy, 0);
    end
    drain();
    chk("stall_xfer", dutXfers, 1); chk("stall_done_vld", oWrVld, 0); chk("stall_done_idle", oIdle, 1);
    step();
    chk("stall_single", dutXfers, 1);

    // Single write closed by the idle timer
    wr(8'h21, 8'h55);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_wait_vld", oWrVld, 0);
    end
    step();
    chk("to_vld", oWrVld, 1); chk("to_addr", oWrAddr, 6'h08);
    chk("to_mask", oWrMask, 4'b0010); chk("to_dat", oWrDat, 32'h00005500);
    drain();
    chk("to_xfer", dutXfers, 2);

    // Different-line write forces issue and waits for IDLE
    wr(8'h10, 8'h11);
    iVld = 1'b1; iAddr = 8'h24; iDat = 8'h22;
    #1;
    chk("miss_rdy", oRdy, 0);
    step();
    chk("miss_vld", oWrVld, 1); chk("miss_addr", oWrAddr, 6'h04);
    chk("miss_mask", oWrMask, 4'b0001); chk("miss_dat", oWrDat, 32'h00000011);
    chk("miss_issue_rdy", oRdy, 0);
    drain();
    chk("miss_idle_rdy", oRdy, 1); chk("miss_xfer", dutXfers, 3);
    step();
    iVld = 1'b0;
    chk("miss_pend_vld", oWrVld, 0); chk("miss_pend_idle", oIdle, 0);
    repeat (3) step();
    chk("miss_wait_vld", oWrVld, 0);
    step();
    chk("miss2_vld", oWrVld, 1); chk("miss2_addr", oWrAddr, 6'h09);
    chk("miss2_mask", oWrMask, 4'b0001); chk("miss2_dat", oWrDat, 32'h00000022);
    drain();
    chk("miss2_xfer", dutXfers, 4);

    // Same-lane rewrite with flush in the same cycle: newest data wins
    wr(8'h30, 8'h01);
    iVld = 1'b1; iAddr = 8'h30; iDat = 8'h02; iFlush = 1'b1;
    step();
    iVld = 1'b0; iFlush = 1'b0;
    chk("flush_vld", oWrVld, 1); chk("flush_addr", oWrAddr, 6'h0C);
    chk("flush_mask", oWrMask, 4'b0001); chk("flush_dat", oWrDat, 32'h00000002);
    drain();
    chk("flush_xfer", dutXfers, 5);

    // Reset while issuing discards the line, even with iWrRdy high
    wr(8'h40, 8'h77);
    iFlush = 1'b1; step(); iFlush = 1'b0;
    chk("rstIss_pre_vld", oWrVld, 1);
    rst = 1'b1; iWrRdy = 1'b1;
    step();
    rst = 1'b0; iWrRdy = 1'b0;
    chk("rstIss_vld", oWrVld, 0); chk("rstIss_idle", oIdle, 1);
    chk("rstIss_mask", oWrMask, 4'b0000); chk("rstIss_dat", oWrDat, 32'h0);
    chk("rstIss_noxfer", dutXfers, 5);
    step(); step();
    chk("rstIss_noxfer2", dutXfers, 5);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
